// File: rtl/rv_reduced_pkg.sv
// Shared encodings and types for the reduced multi-cycle RV32I core.
package rv_reduced_pkg;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_BNE     = 3'b001;

    localparam logic [6:0] F7_ADD = 7'b0000000;
    localparam logic [6:0] F7_SUB = 7'b0100000;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_WRITEBACK,
        S_HALT
    } state_t;

    typedef enum logic {
        ALU_ADD,
        ALU_SUB
    } alu_op_t;

endpackage

// File: rtl/rv_reduced_multicycle_regfile.sv
// Register file: two async read ports, one sync write port, x0 tied to zero.
module rv_regfile
    import rv_reduced_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [REG_ADDR_WIDTH-1:0] i_raddr1,
    input  logic [REG_ADDR_WIDTH-1:0] i_raddr2,
    output logic [DATA_WIDTH-1:0]     o_rdata1,
    output logic [DATA_WIDTH-1:0]     o_rdata2,
    input  logic                      i_we,
    input  logic [REG_ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0]     i_wdata,
    output logic [DATA_WIDTH-1:0]     o_x10
);

    localparam int NREGS = 2 ** REG_ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_regs [NREGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we && (i_waddr != '0)) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata1 = (i_raddr1 == '0) ? '0 : r_regs[i_raddr1];
    assign o_rdata2 = (i_raddr2 == '0) ? '0 : r_regs[i_raddr2];
    assign o_x10    = r_regs[10];

endmodule

// File: rtl/rv_reduced_multicycle.sv
// Multi-cycle core for addi/add/sub/beq/bne with a req/valid instruction fetch.
// Any other encoding parks the core in HALT until reset.
module rv_reduced_multicycle
    import rv_reduced_pkg::*;
#(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    REG_ADDR_WIDTH = 5,
    parameter logic [DATA_WIDTH-1:0] RESET_PC       = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic [31:0]           imem_rdata,
    input  logic                  imem_valid,
    output logic [DATA_WIDTH-1:0] a0,
    output logic                  halted
);

    localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(4);

    state_t r_state, w_next;

    logic [DATA_WIDTH-1:0]     r_pc;
    logic [31:0]               r_ir;
    logic [DATA_WIDTH-1:0]     r_op_a, r_op_b, r_imm, r_result;
    logic [REG_ADDR_WIDTH-1:0] r_rd;
    logic                      r_wr_en, r_is_branch, r_is_bne, r_taken;
    alu_op_t                   r_alu_op;

    logic [6:0]                w_opcode, w_f7;
    logic [2:0]                w_f3;
    logic [REG_ADDR_WIDTH-1:0] w_rd, w_rs1, w_rs2;
    logic [DATA_WIDTH-1:0]     w_rs1_data, w_rs2_data, w_imm_i, w_imm_b, w_alu_out;
    logic                      w_legal, w_wr_en, w_use_imm, w_is_branch, w_is_bne, w_eq;
    alu_op_t                   w_alu_op;

    assign w_opcode = r_ir[6:0];
    assign w_f3     = r_ir[14:12];
    assign w_f7     = r_ir[31:25];
    assign w_rd     = r_ir[7  +: REG_ADDR_WIDTH];
    assign w_rs1    = r_ir[15 +: REG_ADDR_WIDTH];
    assign w_rs2    = r_ir[20 +: REG_ADDR_WIDTH];
    assign w_imm_i  = {{(DATA_WIDTH-12){r_ir[31]}}, r_ir[31:20]};
    assign w_imm_b  = {{(DATA_WIDTH-13){r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};

    rv_regfile #(
        .DATA_WIDTH    (DATA_WIDTH),
        .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .i_raddr1(w_rs1),
        .i_raddr2(w_rs2),
        .o_rdata1(w_rs1_data),
        .o_rdata2(w_rs2_data),
        .i_we    ((r_state == S_WRITEBACK) && r_wr_en),
        .i_waddr (r_rd),
        .i_wdata (r_result),
        .o_x10   (a0)
    );

    always_comb begin
        w_legal     = 1'b0;
        w_wr_en     = 1'b0;
        w_use_imm   = 1'b0;
        w_is_branch = 1'b0;
        w_is_bne    = 1'b0;
        w_alu_op    = ALU_ADD;
        case (w_opcode)
            OP_IMM: begin
                if (w_f3 == F3_ADD_SUB) begin
                    w_legal   = 1'b1;
                    w_wr_en   = 1'b1;
                    w_use_imm = 1'b1;
                end
            end
            OP_REG: begin
                if ((w_f3 == F3_ADD_SUB) && ((w_f7 == F7_ADD) || (w_f7 == F7_SUB))) begin
                    w_legal  = 1'b1;
                    w_wr_en  = 1'b1;
                    w_alu_op = (w_f7 == F7_SUB) ? ALU_SUB : ALU_ADD;
                end
            end
            OP_BRANCH: begin
                if ((w_f3 == F3_BEQ) || (w_f3 == F3_BNE)) begin
                    w_legal     = 1'b1;
                    w_is_branch = 1'b1;
                    w_is_bne    = (w_f3 == F3_BNE);
                end
            end
            default: ;
        endcase
    end

    assign w_alu_out = (r_alu_op == ALU_SUB) ? (r_op_a - r_op_b) : (r_op_a + r_op_b);
    assign w_eq      = (r_op_a == r_op_b);
    assign imem_addr = r_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        imem_req = 1'b0;
        halted   = 1'b0;
        case (r_state)
            S_FETCH: begin
                imem_req = !rst;
                if (imem_valid) w_next = S_DECODE;
            end
            S_DECODE:    w_next = w_legal ? S_EXECUTE : S_HALT;
            S_EXECUTE:   w_next = S_WRITEBACK;
            S_WRITEBACK: w_next = S_FETCH;
            S_HALT:      halted = 1'b1;
            default:     w_next = S_FETCH;
        endcase
    end

    // Operands are captured in DECODE, so rd == rs1 sees the pre-write value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc        <= RESET_PC;
            r_ir        <= '0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_imm       <= '0;
            r_result    <= '0;
            r_rd        <= '0;
            r_wr_en     <= 1'b0;
            r_is_branch <= 1'b0;
            r_is_bne    <= 1'b0;
            r_taken     <= 1'b0;
            r_alu_op    <= ALU_ADD;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (imem_valid) r_ir <= imem_rdata;
                end
                S_DECODE: begin
                    r_op_a      <= w_rs1_data;
                    r_op_b      <= w_use_imm ? w_imm_i : w_rs2_data;
                    r_imm       <= w_imm_b;
                    r_rd        <= w_rd;
                    r_wr_en     <= w_wr_en;
                    r_is_branch <= w_is_branch;
                    r_is_bne    <= w_is_bne;
                    r_alu_op    <= w_alu_op;
                end
                S_EXECUTE: begin
                    r_result <= w_alu_out;
                    r_taken  <= r_is_branch && (w_eq != r_is_bne);
                end
                S_WRITEBACK: begin
                    r_pc <= r_taken ? (r_pc + r_imm) : (r_pc + PC_STEP);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rv_reduced_multicycle.sv
// Bench for rv_reduced_multicycle: an ISA-level interpreter predicts a0, PC and halt per retired instruction.
module tb_rv_reduced_multicycle;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        imem_valid = 1'b0;
    logic [31:0] a0;
    logic        halted;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [64];
    int          mem_delay = 0;
    bit          noise = 1'b0;
    int          wait_cnt = 0;

    logic [31:0] m_regs [32];
    logic [31:0] m_pc;
    bit          m_halt;

    always #5 clk = ~clk;

    rv_reduced_multicycle #(
        .DATA_WIDTH    (32),
        .REG_ADDR_WIDTH(5),
        .RESET_PC      (32'h0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_rdata(imem_rdata),
        .imem_valid(imem_valid),
        .a0        (a0),
        .halted    (halted)
    );

    // Memory responder: valid after mem_delay requesting cycles; optional junk strobes while idle.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (imem_req) begin
                if (wait_cnt >= mem_delay) begin
                    imem_valid = 1'b1;
                    imem_rdata = mem[imem_addr[7:2]];
                end else begin
                    imem_valid = 1'b0;
                    imem_rdata = 32'hdeadbeef;
                    wait_cnt++;
                end
            end else begin
                wait_cnt   = 0;
                imem_valid = noise;
                imem_rdata = noise ? $urandom : 32'h0;
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL timeout: simulation did not finish (actual running, required finished)");
        $fatal(1);
    end

    function automatic logic [31:0] enc_i(int rd, int rs1, int imm);
        return {imm[11:0], rs1[4:0], 3'b000, rd[4:0], 7'b0010011};
    endfunction

    function automatic logic [31:0] enc_r(bit sub, int rd, int rs1, int rs2);
        logic [6:0] f7;
        f7 = sub ? 7'b0100000 : 7'b0000000;
        return {f7, rs2[4:0], rs1[4:0], 3'b000, rd[4:0], 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_b(bit ne, int rs1, int rs2, int imm);
        logic [2:0] f3;
        f3 = ne ? 3'b001 : 3'b000;
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) mem[i] = 32'h00000013;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        m_pc   = 32'h0;
        m_halt = 1'b0;
    endtask

    // Architectural effect of the instruction at m_pc.
    task automatic model_step();
        logic [31:0] ins, a, b;
        int op, f3, f7, rd, imm_i, imm_b;
        ins   = mem[m_pc[7:2]];
        op    = int'(ins[6:0]);
        f3    = int'(ins[14:12]);
        f7    = int'(ins[31:25]);
        rd    = int'(ins[11:7]);
        a     = m_regs[ins[19:15]];
        b     = m_regs[ins[24:20]];
        imm_i = int'($signed(ins)) >>> 20;
        imm_b = (ins[31] ? -4096 : 0) + (int'(ins[7]) << 11) + (int'(ins[30:25]) << 5) + (int'(ins[11:8]) << 1);
        if (op == 'h13 && f3 == 0) begin
            if (rd != 0) m_regs[rd] = a + 32'(imm_i);
            m_pc = m_pc + 4;
        end else if (op == 'h33 && f3 == 0 && (f7 == 0 || f7 == 'h20)) begin
            if (rd != 0) m_regs[rd] = (f7 == 'h20) ? a - b : a + b;
            m_pc = m_pc + 4;
        end else if (op == 'h63 && (f3 == 0 || f3 == 1)) begin
            if ((a == b) == (f3 == 0)) m_pc = m_pc + 32'(imm_b);
            else                       m_pc = m_pc + 4;
        end else begin
            m_halt = 1'b1;
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Leaves the bench at the negedge where rst drops; the DUT's first FETCH cycle is under way.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        clear_mem();
        mem_delay = 0;
        noise = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (imem_req !== 1'b0 || imem_addr !== 32'h0 || halted !== 1'b0 || a0 !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: req=%b addr=%h halted=%b a0=%h, required 0 0 0 0", imem_req, imem_addr, halted, a0);
        end
        @(negedge clk);
        rst = 1'b0;
        noise = 1'b0;
        model_reset();
        #2;
        checks++;
        if (imem_req !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_req: req=%b, required 1", imem_req);
        end
    endtask

    task automatic test_single_addi();
        clear_mem();
        mem[0] = 32'h00500513;
        mem_delay = 0;
        do_reset();
        tick(3);
        checks++;
        if (a0 !== 32'h0) begin
            errors++;
            $display("FAIL addi_early: a0=%h after 3 cycles, required 0", a0);
        end
        tick(1);
        model_step();
        checks++;
        if (a0 !== m_regs[10] || imem_addr !== m_pc || a0 !== 32'd5 || imem_addr !== 32'd4) begin
            errors++;
            $display("FAIL addi_single: a0=%h addr=%h, required a0=%h addr=%h", a0, imem_addr, m_regs[10], m_pc);
        end
    endtask

    task automatic test_add_sub();
        logic [31:0] prev;
        clear_mem();
        mem[0] = 32'h00500513;
        mem[1] = 32'h00300593;
        mem[2] = 32'h00b50533;
        mem[3] = 32'h40b50533;
        mem_delay = 0;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            prev = m_regs[10];
            tick(3);
            checks++;
            if (a0 !== prev) begin
                errors++;
                $display("FAIL addsub_early k=%0d: a0=%h, required %h", k, a0, prev);
            end
            tick(1);
            model_step();
            checks++;
            if (a0 !== m_regs[10] || imem_addr !== m_pc) begin
                errors++;
                $display("FAIL addsub k=%0d: a0=%h addr=%h, required a0=%h addr=%h", k, a0, imem_addr, m_regs[10], m_pc);
            end
        end
        checks++;
        if (a0 !== 32'd5) begin
            errors++;
            $display("FAIL addsub_final: a0=%h, required 5", a0);
        end
    endtask

    task automatic test_countdown();
        clear_mem();
        mem[0] = 32'h00300513;
        mem[1] = 32'hfff50513;
        mem[2] = 32'hfe051ee3;
        mem_delay = 0;
        do_reset();
        for (int k = 0; k < 7; k++) begin
            tick(4);
            model_step();
            checks++;
            if (a0 !== m_regs[10] || imem_addr !== m_pc) begin
                errors++;
                $display("FAIL countdown k=%0d: a0=%h addr=%h, required a0=%h addr=%h", k, a0, imem_addr, m_regs[10], m_pc);
            end
        end
        checks++;
        if (a0 !== 32'd0 || imem_addr !== 32'd12) begin
            errors++;
            $display("FAIL countdown_exit: a0=%h addr=%h, required 0 and 0000000c", a0, imem_addr);
        end
    endtask

    task automatic test_wait_states();
        logic [31:0] prev;
        clear_mem();
        mem[0] = 32'h00500513;
        mem[1] = 32'h00300593;
        mem[2] = 32'h00b50533;
        mem[3] = 32'h40b50533;
        mem_delay = 3;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            prev = m_regs[10];
            for (int c = 0; c < 3; c++) begin
                tick(1);
                checks++;
                if (imem_req !== 1'b1 || a0 !== prev) begin
                    errors++;
                    $display("FAIL wait_req k=%0d c=%0d: req=%b a0=%h, required 1 and %h", k, c, imem_req, a0, prev);
                end
            end
            tick(4);
            model_step();
            checks++;
            if (a0 !== m_regs[10] || imem_addr !== m_pc) begin
                errors++;
                $display("FAIL wait_result k=%0d: a0=%h addr=%h, required a0=%h addr=%h", k, a0, imem_addr, m_regs[10], m_pc);
            end
        end
        mem_delay = 0;
    endtask

    task automatic test_illegal();
        clear_mem();
        mem[0] = enc_i(10, 0, 9);
        mem[1] = 32'h00000073;
        mem_delay = 0;
        do_reset();
        tick(4);
        model_step();
        tick(2);
        model_step();
        checks++;
        if (halted !== m_halt || imem_req !== 1'b0 || a0 !== m_regs[10]) begin
            errors++;
            $display("FAIL halt_entry: halted=%b req=%b a0=%h, required %b 0 %h", halted, imem_req, a0, m_halt, m_regs[10]);
        end
        noise = 1'b1;
        tick(10);
        checks++;
        if (halted !== 1'b1 || imem_req !== 1'b0 || imem_addr !== 32'd4 || a0 !== 32'd9) begin
            errors++;
            $display("FAIL halt_sticky: halted=%b req=%b addr=%h a0=%h, required 1 0 00000004 9", halted, imem_req, imem_addr, a0);
        end
        noise = 1'b0;
        do_reset();
        #2;
        checks++;
        if (halted !== 1'b0 || imem_addr !== 32'h0 || a0 !== 32'h0 || imem_req !== 1'b1) begin
            errors++;
            $display("FAIL halt_reset: halted=%b addr=%h a0=%h req=%b, required 0 0 0 1", halted, imem_addr, a0, imem_req);
        end
    endtask

    task automatic test_rst_mid_execute();
        clear_mem();
        mem[0] = enc_i(10, 0, 5);
        mem[1] = enc_r(1'b0, 10, 10, 10);
        mem_delay = 0;
        do_reset();
        tick(6);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (a0 !== 32'h0 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL rst_exec_hold: a0=%h req=%b, required 0 0", a0, imem_req);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #2;
        checks++;
        if (imem_addr !== 32'h0 || imem_req !== 1'b1) begin
            errors++;
            $display("FAIL rst_exec_restart: addr=%h req=%b, required 00000000 1", imem_addr, imem_req);
        end
        for (int k = 0; k < 2; k++) begin
            tick(4);
            model_step();
            checks++;
            if (a0 !== m_regs[10] || imem_addr !== m_pc) begin
                errors++;
                $display("FAIL rst_exec_rerun k=%0d: a0=%h addr=%h, required a0=%h addr=%h", k, a0, imem_addr, m_regs[10], m_pc);
            end
        end
    endtask

    task automatic test_x0();
        clear_mem();
        mem[0] = enc_i(10, 0, 3);
        mem[1] = enc_i(0, 0, 7);
        mem[2] = enc_r(1'b0, 10, 10, 0);
        mem_delay = 0;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            tick(4);
            model_step();
        end
        checks++;
        if (a0 !== m_regs[10] || a0 !== 32'd3) begin
            errors++;
            $display("FAIL x0_zero: a0=%h, required %h", a0, m_regs[10]);
        end
    endtask

    task automatic test_random();
        int n, kind, rd, imm, guard;
        for (int round = 0; round < 4; round++) begin
            clear_mem();
            n = 24;
            for (int i = 0; i < 6; i++) mem[i] = enc_i(8 + i, 0, int'($urandom_range(0, 4095)) - 2048);
            for (int i = 6; i < n; i++) begin
                kind = int'($urandom_range(0, 9));
                rd   = ($urandom_range(0, 1) == 1) ? 10 : int'($urandom_range(0, 15));
                imm  = int'($urandom_range(0, 4095)) - 2048;
                if (kind < 3)      mem[i] = enc_i(rd, int'($urandom_range(0, 15)), imm);
                else if (kind < 6) mem[i] = enc_r(1'b0, rd, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
                else if (kind < 8) mem[i] = enc_r(1'b1, rd, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
                else               mem[i] = enc_b(kind == 9, int'($urandom_range(8, 11)), int'($urandom_range(0, 11)), 8);
            end
            mem_delay = int'($urandom_range(0, 2));
            noise = 1'b1;
            do_reset();
            guard = 0;
            while (m_pc < 32'(4 * n) && guard < 64) begin
                tick(4 + mem_delay);
                model_step();
                guard++;
                checks++;
                if (a0 !== m_regs[10] || imem_addr !== m_pc || halted !== 1'b0) begin
                    errors++;
                    $display("FAIL random r=%0d step=%0d: a0=%h addr=%h halted=%b, required a0=%h addr=%h halted=0",
                             round, guard, a0, imem_addr, halted, m_regs[10], m_pc);
                end
            end
            noise = 1'b0;
        end
        mem_delay = 0;
    endtask

    initial begin
        model_reset();
        clear_mem();
        test_reset();
        test_single_addi();
        test_add_sub();
        test_countdown();
        test_wait_states();
        test_illegal();
        test_rst_mid_execute();
        test_x0();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv_reduced_multicycle.md
Name: rv_reduced_multicycle

Overview:
- Parametrised successor to the single-cycle reduced RISC-V top.
- Runs a multi-cycle reduced RV32I subset (addi, add, sub, beq, bne) through a fetch/decode/execute/writeback FSM.
- Fetches from an external instruction memory over a variable-latency req/valid handshake.
- Exposes register x10 as a0 for the bench and raises halted on any unsupported encoding.

Parameters:
- DATA_WIDTH, 32: register, ALU and PC width.
- REG_ADDR_WIDTH, 5: register-file address width; the file holds 2**REG_ADDR_WIDTH registers.
- RESET_PC, 0: PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- imem_req  output  1  fetch request; held high for the whole FETCH state.
- imem_addr  output  DATA_WIDTH  byte address of the fetch; equals PC.
- imem_rdata  input  32  instruction word; sampled on the edge where imem_valid=1.
- imem_valid  input  1  instruction word valid; honoured only in FETCH.
- a0  output  DATA_WIDTH  current value of register x10.
- halted  output  1  sticky high after an illegal instruction.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: PC=RESET_PC, all registers 0, state=FETCH, IR=0, a0=0, halted=0. imem_req=0 during any cycle in which rst=1.
- FSM states: FETCH, DECODE, EXECUTE, WRITEBACK, HALT.
- FETCH: imem_req=1, imem_addr=PC. On an edge with imem_valid=1, IR<=imem_rdata and go to DECODE; otherwise stay in FETCH with no timeout.
- DECODE: read rs1 and rs2; generate the I-type or B-type immediate, sign-extended to DATA_WIDTH; classify the opcode.
  - Legal encodings: opcode 0010011 with f3 000; opcode 0110011 with f3 000 and f7 0000000 or 0100000; opcode 1100011 with f3 000 or 001.
  - A legal encoding goes to EXECUTE. Anything else goes to HALT.
- EXECUTE: ALU computes add or sub modulo 2**DATA_WIDTH. Branch compare: EQ = (rs1 == rs2). Result and branch-taken flag are latched.
- WRITEBACK:
  - addi, add, sub write rd; a write with rd=0 is dropped.
  - Branch taken: PC<=PC+imm. Otherwise PC<=PC+4. PC wraps modulo 2**DATA_WIDTH.
  - Next state is FETCH.
- HALT: terminal. halted=1, imem_req=0, PC and registers frozen. Only rst leaves HALT.
- Latency: 4 cycles per instruction with zero-wait memory, plus 1 cycle per imem_valid-low cycle in FETCH.
- a0 is combinational from x10 and reflects a write on the cycle after the WRITEBACK edge.
- x0 always reads 0.
- imem_valid outside FETCH is ignored and imem_rdata is not captured.
- rst asserted in any state, including mid-fetch with a request outstanding, abandons the instruction. The next cycle is FETCH at RESET_PC. A late imem_valid that arrives in that first cycle is treated as the response to the new fetch.
- rd == rs1 (for example, addi x10,x10,-1) uses the old value, because operands are read in DECODE.
- Branch immediates are not checked for alignment; bit 0 of the B immediate is 0 by encoding.

Decomposition:
- Package rv_reduced_pkg holds:
  - opcode constants OP_IMM, OP_REG, OP_BRANCH;
  - funct3 and funct7 constants;
  - state_t enum for the FSM;
  - alu_op_t enum {ALU_ADD, ALU_SUB}.
- One sub-module: rv_regfile.
  - Parametrised by DATA_WIDTH and REG_ADDR_WIDTH.
  - Two asynchronous read ports, one synchronous write port.
  - x0 is hard-wired to zero.
  - Synchronous reset clears all registers.
  - Also exports x10 as a dedicated output for a0.
- ALU, immediate generation and FSM stay in the top module.

Test Plan:
- Zero-wait memory, program 0x00500513 (addi x10,x0,5) -> a0=5 exactly 4 cycles after reset release; imem_addr advances to 4.
- Program 0x00500513, 0x00300593, 0x00b50533, 0x40b50533 -> a0 reads 5, then 5, then 8, then 5. Each change lands 4 cycles after the previous one.
- Countdown loop 0x00300513, 0xfff50513, 0xfe051ee3 -> a0 reads 3, 2, 1, 0. Branch taken twice (PC 8 -> 4), then falls through to PC=12.
- imem_valid delayed 3 cycles on every fetch -> same architectural results as zero-wait; 7 cycles per instruction; imem_req stays high throughout each wait.
- Fetch 0x00000073 (ecall) -> halted=1 after DECODE; imem_req=0; a0 unchanged; stays halted until rst; after rst, halted=0 and PC=RESET_PC.
- Extra directed checks:
  - rst pulsed while in EXECUTE of an add -> no register write; next cycle FETCH at RESET_PC.
  - addi x0,x0,7 -> x0 still reads 0.
